// File: rtl/fm_pingpong_buffer_ctrl_pkg.sv
// Shared feature-map buffer parameters.
// Default geometry (FM_WIDTH x FM_HEIGHT, STRIDE) and helpers deriving the
// words-per-bank depth and the bank address width. Reused by the buffer RAM
// wrapper and the downstream consumer so all three agree on bank layout.
package fm_pingpong_buffer_ctrl_pkg;

  localparam int unsigned FM_WIDTH_DEF  = 8;
  localparam int unsigned FM_HEIGHT_DEF = 8;
  localparam int unsigned STRIDE_DEF    = 2;

  // Words stored per bank after decimation.
  function automatic int unsigned fm_depth(input int unsigned width,
                                           input int unsigned height,
                                           input int unsigned stride);
    return (width / stride) * (height / stride);
  endfunction

  // Address width for a bank; kept at least 1 so a single-word bank still
  // has a legal port width.
  function automatic int unsigned fm_abits(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fm_stride_sampler.sv
// Combinational decimation sample detect.
// A coordinate is kept when data is valid and the low log2(STRIDE) bits of
// both xcoord and ycoord are all ones (last pixel of each STRIDE x STRIDE
// tile). STRIDE=1 gives an all-zero mask, so every valid cycle is sampled.
//   i_data_rdy : producer coordinates valid
//   i_xcoord   : pixel column
//   i_ycoord   : pixel row
//   o_sample   : this coordinate is a decimated sample
module fm_stride_sampler #(
  parameter int unsigned X_BITS = 3,
  parameter int unsigned Y_BITS = 3,
  parameter int unsigned STRIDE = 2
) (
  input  logic              i_data_rdy,
  input  logic [X_BITS-1:0] i_xcoord,
  input  logic [Y_BITS-1:0] i_ycoord,
  output logic              o_sample
);

  localparam logic [X_BITS-1:0] X_MASK = X_BITS'(STRIDE - 1);
  localparam logic [Y_BITS-1:0] Y_MASK = Y_BITS'(STRIDE - 1);

  assign o_sample = i_data_rdy &&
                    ((i_xcoord & X_MASK) == X_MASK) &&
                    ((i_ycoord & Y_MASK) == Y_MASK);

endmodule

// File: rtl/fm_pingpong_buffer_ctrl.sv
// Ping-pong feature-map buffer write-address and bank controller.
// Decimates the incoming raster, writes samples sequentially into the current
// bank, and hands each completed bank to the consumer via rd_valid/rd_release.
//   i_clk          : clock, rising edge
//   i_rst_n        : asynchronous active-low reset
//   i_data_rdy     : coordinates valid; low discards the partial frame
//   i_xcoord       : pixel column
//   i_ycoord       : pixel row
//   o_wr_en        : RAM write strobe (combinational)
//   o_wr_bank      : bank being written
//   o_wr_addr      : word address within o_wr_bank
//   o_rd_valid     : o_rd_bank is full and readable
//   o_rd_bank      : bank the consumer must read
//   i_rd_release   : one-cycle pulse, consumer finished o_rd_bank
//   o_frame_done   : one-cycle pulse after a bank completes
//   o_buffer_full  : both banks full
//   o_overflow     : sticky, a sample was dropped
module fm_pingpong_buffer_ctrl
  import fm_pingpong_buffer_ctrl_pkg::*;
#(
  parameter int unsigned FM_WIDTH  = FM_WIDTH_DEF,
  parameter int unsigned FM_HEIGHT = FM_HEIGHT_DEF,
  parameter int unsigned STRIDE    = STRIDE_DEF,
  parameter int unsigned X_BITS    = $clog2(FM_WIDTH),
  parameter int unsigned Y_BITS    = $clog2(FM_HEIGHT),
  localparam int unsigned DEPTH    = fm_depth(FM_WIDTH, FM_HEIGHT, STRIDE),
  localparam int unsigned A_BITS   = fm_abits(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_data_rdy,
  input  logic [X_BITS-1:0] i_xcoord,
  input  logic [Y_BITS-1:0] i_ycoord,
  output logic              o_wr_en,
  output logic              o_wr_bank,
  output logic [A_BITS-1:0] o_wr_addr,
  output logic              o_rd_valid,
  output logic              o_rd_bank,
  input  logic              i_rd_release,
  output logic              o_frame_done,
  output logic              o_buffer_full,
  output logic              o_overflow
);

  localparam logic [A_BITS-1:0] LAST_ADDR = A_BITS'(DEPTH - 1);

  logic [A_BITS-1:0] r_cnt;
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_full;
  logic              r_overflow;
  logic              r_frame_done;

  logic              w_sample;
  logic              w_writable;
  logic              w_wr_en;
  logic              w_last;
  logic              w_release;
  logic [1:0]        w_full_set;
  logic [1:0]        w_full_clr;

  fm_stride_sampler #(
    .X_BITS (X_BITS),
    .Y_BITS (Y_BITS),
    .STRIDE (STRIDE)
  ) u_sampler (
    .i_data_rdy (i_data_rdy),
    .i_xcoord   (i_xcoord),
    .i_ycoord   (i_ycoord),
    .o_sample   (w_sample)
  );

  // Writability looks only at registered full[], so a release landing in the
  // same cycle as a sample to that bank does not rescue the sample.
  assign w_writable = !r_full[r_wr_ptr];
  assign w_wr_en    = w_sample && w_writable;
  assign w_last     = (r_cnt == LAST_ADDR);
  assign w_release  = i_rd_release && r_full[r_rd_ptr];

  // Completing a bank and releasing one in the same cycle always target
  // different banks (a release needs full[rd_ptr], a write needs
  // !full[wr_ptr]), so set and clear never collide on one bit.
  always_comb begin
    w_full_set = 2'b00;
    w_full_clr = 2'b00;
    if (w_wr_en && w_last) w_full_set[r_wr_ptr] = 1'b1;
    if (w_release)         w_full_clr[r_rd_ptr] = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt        <= '0;
      r_wr_ptr     <= 1'b0;
      r_rd_ptr     <= 1'b0;
      r_full       <= 2'b00;
      r_overflow   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_wr_en && w_last;
      r_full       <= (r_full | w_full_set) & ~w_full_clr;

      if (!i_data_rdy) begin
        r_cnt <= '0;
      end else if (w_wr_en) begin
        if (w_last) begin
          r_cnt    <= '0;
          r_wr_ptr <= ~r_wr_ptr;
        end else begin
          r_cnt <= r_cnt + A_BITS'(1);
        end
      end

      if (w_sample && !w_writable) r_overflow <= 1'b1;
      if (w_release)               r_rd_ptr   <= ~r_rd_ptr;
    end
  end

  assign o_wr_en       = w_wr_en;
  assign o_wr_bank     = r_wr_ptr;
  assign o_wr_addr     = r_cnt;
  assign o_rd_valid    = r_full[r_rd_ptr];
  assign o_rd_bank     = r_rd_ptr;
  assign o_frame_done  = r_frame_done;
  assign o_buffer_full = r_full[0] & r_full[1];
  assign o_overflow    = r_overflow;

endmodule
